// File: rtl/wallace_11bit.sv
// wallace_11bit: unsigned 11x11 multiplier built as a Wallace carry-save tree,
// followed by a 23-bit ripple-carry adder. Only the product is registered.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset, clears p immediately
//   a      in  11  unsigned multiplicand
//   b      in  11  unsigned multiplier
//   p      out 23  registered product a*b (p[22] is always 0)
//
// Carry-save probe points (23 bits each):
//   u1/v1  first reduction layer (rows 0..2)
//   u2/v2  middle reduction layer
//   u3/v3  final pair feeding the adder, u3 + v3 == a*b
module wallace_11bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] a,
    input  logic [10:0] b,
    output logic [22:0] p
);

    typedef logic [22:0] row_t;

    // 3:2 compressor applied bitwise across all columns. Where one input
    // row is zero in a column it degenerates to a half adder.
    function automatic row_t csa_sum(input row_t x, input row_t y, input row_t z);
        return x ^ y ^ z;
    endfunction

    // Carry is returned already shifted into its column weight.
    function automatic row_t csa_carry(input row_t x, input row_t y, input row_t z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    row_t pp [11];
    row_t l1 [8];
    row_t l2 [6];
    row_t l3 [4];
    row_t l4 [3];

    row_t u1, v1, u2, v2, u3, v3;
    row_t sum_final;

    // Partial products
    always_comb begin
        for (int i = 0; i < 11; i++) begin
            pp[i] = b[i] ? (row_t'(a) << i) : '0;
        end
    end

    // Layer 1: 11 rows -> 8 rows
    always_comb begin
        u1    = csa_sum  (pp[0], pp[1], pp[2]);
        v1    = csa_carry(pp[0], pp[1], pp[2]);
        l1[0] = u1;
        l1[1] = v1;
        l1[2] = csa_sum  (pp[3], pp[4], pp[5]);
        l1[3] = csa_carry(pp[3], pp[4], pp[5]);
        l1[4] = csa_sum  (pp[6], pp[7], pp[8]);
        l1[5] = csa_carry(pp[6], pp[7], pp[8]);
        l1[6] = pp[9];
        l1[7] = pp[10];
    end

    // Layer 2: 8 rows -> 6 rows
    always_comb begin
        l2[0] = csa_sum  (l1[0], l1[1], l1[2]);
        l2[1] = csa_carry(l1[0], l1[1], l1[2]);
        l2[2] = csa_sum  (l1[3], l1[4], l1[5]);
        l2[3] = csa_carry(l1[3], l1[4], l1[5]);
        l2[4] = l1[6];
        l2[5] = l1[7];
    end

    // Layer 3 (middle): 6 rows -> 4 rows
    always_comb begin
        u2    = csa_sum  (l2[0], l2[1], l2[2]);
        v2    = csa_carry(l2[0], l2[1], l2[2]);
        l3[0] = u2;
        l3[1] = v2;
        l3[2] = csa_sum  (l2[3], l2[4], l2[5]);
        l3[3] = csa_carry(l2[3], l2[4], l2[5]);
    end

    // Layer 4: 4 rows -> 3 rows
    always_comb begin
        l4[0] = csa_sum  (l3[0], l3[1], l3[2]);
        l4[1] = csa_carry(l3[0], l3[1], l3[2]);
        l4[2] = l3[3];
    end

    // Layer 5: 3 rows -> final carry-save pair
    always_comb begin
        u3 = csa_sum  (l4[0], l4[1], l4[2]);
        v3 = csa_carry(l4[0], l4[1], l4[2]);
    end

    // Final ripple-carry adder; carry out of bit 22 is dropped (never set).
    always_comb begin
        logic c;
        c         = 1'b0;
        sum_final = '0;
        for (int i = 0; i < 23; i++) begin
            sum_final[i] = u3[i] ^ v3[i] ^ c;
            c            = (u3[i] & v3[i]) | (c & (u3[i] ^ v3[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else begin
            p <= sum_final;
        end
    end

endmodule

// File: tb/tb_wallace_11bit.sv
// Scoreboard bench for wallace_11bit: stimulus pushes expected products into
// a queue at the negedge it drives a/b; a monitor pops and compares one
// expected value per rising edge while the queue holds pending results.
module tb_wallace_11bit;

    logic        clk;
    logic        rst_n;
    logic [10:0] a;
    logic [10:0] b;
    logic [22:0] p;

    logic [22:0] exp_q [$];
    int          errors;
    int          checks;

    wallace_11bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .p     (p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Drive one operand pair before the next rising edge and queue its product.
    task automatic issue(input logic [10:0] ia, input logic [10:0] ib);
        logic [22:0] prod;
        @(negedge clk);
        a    = ia;
        b    = ib;
        prod = 23'(ia) * 23'(ib);
        exp_q.push_back(prod);
        #1;
        check("u3+v3", 23'(dut.u3 + dut.v3), prod);
    endtask

    // Monitor: compare the registered product one edge after capture.
    always @(posedge clk) begin
        logic [22:0] e;
        #1;
        if (rst_n && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("p", p, e);
        end
    end

    initial begin
        logic [10:0] corners [4];
        logic [10:0] ra, rb;
        errors     = 0;
        checks     = 0;
        corners[0] = 11'd0;
        corners[1] = 11'd1;
        corners[2] = 11'd1024;
        corners[3] = 11'd2047;

        // Reset held with maximum operands: p stays zero through clock edges.
        rst_n = 1'b0;
        a     = 11'h7FF;
        b     = 11'h7FF;
        #1;
        check("reset_async", p, 23'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", p, 23'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_no_edge", p, 23'd0);
        issue(11'd2047, 11'd2047);      // expect 4190209

        // Significand case and identity/zero
        issue(11'd1280, 11'd1280);      // 1638400
        issue(11'd1, 11'd1234);         // 1234
        issue(11'd0, 11'd2047);         // 0
        issue(11'd2047, 11'd1);         // 2047

        // Back-to-back
        issue(11'd3, 11'd5);            // 15
        issue(11'd1024, 11'd1024);      // 1048576
        issue(11'd2047, 11'd2047);      // 4190209

        // Mid-stream reset while p holds 1048576
        issue(11'd1024, 11'd1024);
        @(posedge clk);
        #2;
        check("pre_reset_value", p, 23'd1048576);
        rst_n = 1'b0;
        #1;
        check("midstream_reset", p, 23'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_idle", p, 23'd0);
        issue(11'd1234, 11'd567);       // 699678

        // Corner sweeps
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                issue(corners[i], corners[j]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            ra = 11'($urandom_range(0, 2047));
            issue(corners[i], ra);
            issue(ra, corners[i]);
        end

        // Random pairs
        for (int n = 0; n < 20000; n++) begin
            ra = 11'($urandom_range(0, 2047));
            rb = 11'($urandom_range(0, 2047));
            issue(ra, rb);
        end

        // Drain: every queued product must have been compared.
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 23'(exp_q.size()), 23'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
